// File: rtl/solo_squash_pkg.sv
// Shared constants for the solo_squash input conditioning logic.
//   N_INPUTS          : number of active-low button channels
//   DEBOUNCE_MAX_DFLT : default stable-cycle count to accept a level
//   IDX_*             : bit positions of each button within raw_n / clean_n
//   cnt_width()       : width of the per-channel qualification counter
package solo_squash_pkg;

    localparam int N_INPUTS          = 5;
    localparam int DEBOUNCE_MAX_DFLT = 50000;

    localparam int IDX_EXT_RESET = 0;
    localparam int IDX_PAUSE     = 1;
    localparam int IDX_NEW_GAME  = 2;
    localparam int IDX_DOWN      = 3;
    localparam int IDX_UP        = 4;

    // Counter only has to reach max_count-1, so clog2(max_count) bits suffice.
    // The counter is never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/solo_squash_debounce_channel.sv
// One debounced button channel.
// Ports:
//   clk           : clock
//   rst           : synchronous active-high reset
//   clr           : synchronous clear, same effect as rst (pads not ready)
//   raw_n         : asynchronous active-low pad input
//   clean_n       : debounced active-low level
//   press         : one-cycle pulse on an accepted 1->0 change of clean_n
//   release_pulse : one-cycle pulse on an accepted 0->1 change of clean_n
module solo_squash_debounce_channel #(
    parameter int DEBOUNCE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic raw_n,
    output logic clean_n,
    output logic press,
    output logic release_pulse
);
    import solo_squash_pkg::*;

    localparam int             CW       = cnt_width(DEBOUNCE_MAX);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_MAX - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // Pulses are set in the same edge that updates stable, so they line up
    // with the first cycle clean_n shows the new level.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            stable        <= 1'b1;
            cnt           <= '0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= raw_n;
            sync2         <= sync1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (sync2 == stable) begin
                // Any sample matching the accepted level restarts qualification.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable        <= sync2;
                cnt           <= '0;
                press         <= ~sync2;
                release_pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign clean_n = stable;

endmodule

// File: rtl/solo_squash_input_conditioner.sv
// Debounce and edge-detect the solo_squash button pads.
// Ports:
//   wb_clk_i      : the only clock
//   wb_rst_i      : synchronous active-high reset, dominates everything
//   gpio_ready    : high once pads are configured; low holds the block idle
//   raw_n         : asynchronous active-low pads
//                   [0] ext_reset [1] pause [2] new_game [3] down [4] up
//   clean_n       : debounced active-low levels
//   press         : one-cycle pulse per accepted 1->0 transition
//   release_pulse : one-cycle pulse per accepted 0->1 transition
//                   ("release" is a reserved word, hence the suffix)
module solo_squash_input_conditioner #(
    parameter int N_INPUTS     = solo_squash_pkg::N_INPUTS,
    parameter int DEBOUNCE_MAX = solo_squash_pkg::DEBOUNCE_MAX_DFLT
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                gpio_ready,
    input  logic [N_INPUTS-1:0] raw_n,
    output logic [N_INPUTS-1:0] clean_n,
    output logic [N_INPUTS-1:0] press,
    output logic [N_INPUTS-1:0] release_pulse
);

    logic [N_INPUTS-1:0] stable_n;
    logic [N_INPUTS-1:0] press_q;
    logic [N_INPUTS-1:0] release_q;

    // Not-ready clears every channel register, so a level held through the
    // rise of gpio_ready must fully requalify, and dropping gpio_ready never
    // produces a release pulse.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_ch
        solo_squash_debounce_channel #(
            .DEBOUNCE_MAX (DEBOUNCE_MAX)
        ) u_ch (
            .clk           (wb_clk_i),
            .rst           (wb_rst_i),
            .clr           (~gpio_ready),
            .raw_n         (raw_n[i]),
            .clean_n       (stable_n[i]),
            .press         (press_q[i]),
            .release_pulse (release_q[i])
        );
    end

    // Outputs are masked immediately while not ready, before the channel
    // registers have been cleared by the next edge.
    assign clean_n       = gpio_ready ? stable_n  : '1;
    assign press         = gpio_ready ? press_q   : '0;
    assign release_pulse = gpio_ready ? release_q : '0;

endmodule

// File: tb/tb_solo_squash_input_conditioner.sv
module tb_solo_squash_input_conditioner;
    localparam int NI   = 5;
    localparam int D    = 4;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic [NI-1:0] raw_n;
    logic [NI-1:0] clean_n;
    logic [NI-1:0] press;
    logic [NI-1:0] rel;

    always #5 clk = ~clk;

    solo_squash_input_conditioner #(
        .N_INPUTS     (NI),
        .DEBOUNCE_MAX (D)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .gpio_ready    (rdy),
        .raw_n         (raw_n),
        .clean_n       (clean_n),
        .press         (press),
        .release_pulse (rel)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [NI-1:0] obs, input logic [NI-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once DEBOUNCE_MAX consecutive
    // synchronized samples disagree with the accepted level, counting only
    // samples taken since the last acceptance / reset / not-ready edge.
    logic [NI-1:0] s2h [0:MAXC-1];   // synchronizer output after each edge
    int            last_f [NI];      // last edge that restarted qualification
    logic [NI-1:0] m_stable = '1;
    logic [NI-1:0] m_press  = '0;
    logic [NI-1:0] m_rel    = '0;
    logic [NI-1:0] cap_prev = '1;    // first-flop content
    int            t = 0;

    task automatic model_edge();
        logic blk;
        bit   ok;
        blk     = rst || !rdy;
        m_press = '0;
        m_rel   = '0;
        if (blk) begin
            m_stable = '1;
            for (int i = 0; i < NI; i++) last_f[i] = t;
        end else begin
            for (int i = 0; i < NI; i++) begin
                ok = (last_f[i] <= t - D);
                if (ok)
                    for (int j = t - D; j < t; j++)
                        if (s2h[j][i] == m_stable[i]) ok = 0;
                if (ok) begin
                    if (m_stable[i]) m_press[i] = 1'b1;
                    else             m_rel[i]   = 1'b1;
                    m_stable[i] = ~m_stable[i];
                    last_f[i]   = t;
                end
            end
        end
        s2h[t]   = blk ? '1 : cap_prev;
        cap_prev = blk ? '1 : raw_n;
        t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("clean", clean_n, m_stable);
        chk("press", press, m_press);
        chk("release", rel, m_rel);
        chk("excl", press & rel, '0);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) last_f[i] = 0;
        rst = 1'b1; rdy = 1'b1; raw_n = '1;
        run(2);
        rst = 1'b0;
        tick();
        chk("rst_clean", clean_n, 5'b11111);
        chk("rst_press", press, 5'b00000);
        chk("rst_release", rel, 5'b00000);

        // clean press on down key: capture at edge k, accept at k+5
        raw_n[3] = 1'b0;
        run(5);
        chk("p_pre_clean", clean_n, 5'b11111);
        tick();
        chk("p_clean", clean_n, 5'b10111);
        chk("p_press", press, 5'b01000);
        tick();
        chk("p_after", press, 5'b00000);

        // three-cycle glitch on pause must be ignored
        raw_n[1] = 1'b0;
        run(3);
        raw_n[1] = 1'b1;
        run(8);
        chk("glitch_clean", clean_n, 5'b10111);

        // release of down key
        raw_n[3] = 1'b1;
        run(5);
        chk("r_pre", rel, 5'b00000);
        tick();
        chk("r_rel", rel, 5'b01000);
        chk("r_clean", clean_n, 5'b11111);
        tick();
        chk("r_after", rel, 5'b00000);

        // gpio_ready gating with up key held
        rdy = 1'b0;
        raw_n[4] = 1'b0;
        run(20);
        chk("gate_clean", clean_n, 5'b11111);
        chk("gate_pulse", press | rel, 5'b00000);
        rdy = 1'b1;
        run(5);
        chk("gate_pre", press, 5'b00000);
        tick();
        chk("gate_press", press, 5'b10000);
        raw_n[4] = 1'b1;
        run(8);

        // ready drops while a key is accepted low: no release pulse
        raw_n[2] = 1'b0;
        run(8);
        chk("drop_held", clean_n, 5'b11011);
        rdy = 1'b0;
        tick();
        chk("drop_clean", clean_n, 5'b11111);
        chk("drop_rel", rel, 5'b00000);
        rdy = 1'b1;
        raw_n[2] = 1'b1;
        run(8);

        // reset mid-qualification
        raw_n[0] = 1'b0;
        run(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2);
        chk("rq_k5", press, 5'b00000);
        run(3);
        chk("rq_pre", press, 5'b00000);
        tick();
        chk("rq_press", press, 5'b00001);
        raw_n[0] = 1'b1;
        run(8);

        // randomized segments with varying bounce rates
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = $urandom_range(2, 12);
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < NI; i++)
                    if ($urandom_range(0, rate - 1) == 0) raw_n[i] = ~raw_n[i];
                if (rdy) begin
                    if ($urandom_range(0, 149) == 0) rdy = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    rdy = 1'b1;
                end
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
